// File: rtl/abc_rr_arbiter.sv
// abc_rr_arbiter: three-way round-robin arbiter with hold limit and preemption.
// Defining ABC_ARB_TURNAROUND_EN adds a TURN state that inserts one idle cycle between owners.
module abc_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       req_c,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       gnt_c,
    output logic       busy,
    output logic       preempt,
    output logic [1:0] owner
);
`ifdef ABC_ARB_TURNAROUND_EN
    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
    state_t state_q, state_d;
    logic [2:0] req, cand, gnt_q, gnt_d;
    logic [1:0] last_q, last_d, n1, n2, win;
    logic [3:0] hold_q, hold_d;
    logic pre_q, pre_d, keep, handoff, take, drop;
    assign req = {req_c, req_b, req_a};
    assign cand = (state_q == GRANT) ? req & ~gnt_q : req;
    assign keep = |(req & gnt_q);
    // Search the two requesters after the pointer first, the pointer itself last.
    assign n1 = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    assign n2 = (last_q == 2'd0) ? 2'd2 : last_q - 2'd1;
    assign win = cand[n1] ? n1 : cand[n2] ? n2 : last_q;
    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        last_d = last_q;
        hold_d = hold_q;
        pre_d = 1'b0;
        handoff = 1'b0;
        take = 1'b0;
        drop = 1'b0;
        case (state_q)
            IDLE: take = |cand;
            GRANT: begin
                if (!keep) begin
                    handoff = |cand;
                    drop = ~|cand;
                end else if (hold_q < HOLD_MAX) begin
                    hold_d = hold_q + 4'd1;
                end else if (|cand) begin
                    pre_d = 1'b1;
                    handoff = 1'b1;
                end
            end
`ifdef ABC_ARB_TURNAROUND_EN
            TURN: begin
                take = |cand;
                drop = ~|cand;
            end
`endif
            default: drop = 1'b1;
        endcase
`ifdef ABC_ARB_TURNAROUND_EN
        if (handoff) begin
            state_d = TURN;
            gnt_d = '0;
            hold_d = '0;
        end
`else
        take = take | handoff;
`endif
        if (take) begin
            state_d = GRANT;
            gnt_d = 3'b001 << win;
            last_d = win;
            hold_d = 4'd1;
        end
        if (drop) begin
            state_d = IDLE;
            gnt_d = '0;
            hold_d = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q <= '0;
            last_q <= 2'd2;
            hold_q <= '0;
            pre_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            last_q <= last_d;
            hold_q <= hold_d;
            pre_q <= pre_d;
        end
    end
    assign gnt_a = gnt_q[0];
    assign gnt_b = gnt_q[1];
    assign gnt_c = gnt_q[2];
    assign busy = (state_q == GRANT);
    assign preempt = pre_q;
    assign owner = gnt_q[0] ? 2'd1 : gnt_q[1] ? 2'd2 : gnt_q[2] ? 2'd3 : 2'd0;
endmodule

// File: tb/tb_abc_rr_arbiter.sv
// tb_abc_rr_arbiter: directed scenarios plus randomized requests checked against a behavioural model.
module tb_abc_rr_arbiter;
    localparam int MH = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
    logic gnt_a, gnt_b, gnt_c, busy, preempt;
    logic [1:0] owner;
    int total = 0, bad = 0;
    int m_own = 0, m_hold = 0, m_last = 3;
    bit m_turn = 0, m_pre = 0;
    logic [3:1] prev_req = '0;
    bit b_seen = 0;

    abc_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_c(gnt_c),
        .busy(busy), .preempt(preempt), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_own = 0; m_hold = 0; m_last = 3; m_turn = 0; m_pre = 0;
    endfunction

    // Client numbering 1=a 2=b 3=c; scan forward from the last granted client.
    function automatic void give(input logic [3:1] x);
        m_own = 0; m_hold = 0;
        for (int k = 3; k >= 1; k--) begin
            int c = (m_last - 1 + k) % 3 + 1;
            if (x[c]) m_own = c;
        end
        if (m_own != 0) begin m_last = m_own; m_hold = 1; end
    endfunction

    function automatic void release_to(input logic [3:1] x);
        if (x == 0) begin
            m_own = 0; m_hold = 0;
        end else begin
`ifdef ABC_ARB_TURNAROUND_EN
            m_own = 0; m_hold = 0; m_turn = 1;
`else
            give(x);
`endif
        end
    endfunction

    function automatic void step(input logic [3:1] r);
        logic [3:1] others = r;
        m_pre = 0;
        if (m_own != 0) others[m_own] = 1'b0;
        if (m_turn) begin m_turn = 0; give(r); end
        else if (m_own == 0) give(r);
        else if (!r[m_own]) release_to(others);
        else if (m_hold < MH) m_hold++;
        else if (others != 0) begin m_pre = 1; release_to(others); end
    endfunction

    task automatic compare();
        logic [3:1] g = {gnt_c, gnt_b, gnt_a};
        chk("gnt", int'(g), m_own == 0 ? 0 : (1 << (m_own - 1)));
        chk("owner", int'(owner), m_own);
        chk("busy", int'(busy), int'(m_own != 0));
        chk("preempt", int'(preempt), int'(m_pre));
        chk("onehot", int'($countones(g) <= 1), 1);
        chk("gnt_without_req", int'(g & ~prev_req), 0);
        if (gnt_b) b_seen = 1;
    endtask

    task automatic cyc(input logic [3:1] r);
        {req_c, req_b, req_a} = r;
        @(posedge clk);
        if (rst_n) begin step(r); prev_req = r; end
        else begin m_reset(); prev_req = '0; end
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        repeat (2) cyc(3'b000);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:1] cur;
        // reset then single requester b
        m_reset();
        cyc(3'b000);
        cyc(3'b000);
        chk("rst_owner", int'(owner), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        cyc(3'b010);
        chk("b_gnt", int'(gnt_b), 1);
        chk("b_owner", int'(owner), 2);
        chk("b_busy", int'(busy), 1);
        repeat (10) cyc(3'b010);
        chk("b_hold", int'(gnt_b), 1);
        chk("b_nopre", int'(preempt), 0);
        // all three requesting: rotation with preemption
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(3'b111);
`ifdef ABC_ARB_TURNAROUND_EN
            chk("rr_seq", int'(owner), (i % 5 == 4) ? 0 : (i / 5) % 3 + 1);
            chk("rr_pre", int'(preempt), int'(i % 5 == 4));
`else
            chk("rr_seq", int'(owner), (i / 4) % 3 + 1);
            chk("rr_pre", int'(preempt), int'(i > 0 && i % 4 == 0));
`endif
        end
        // voluntary release a -> c
        do_reset();
        cyc(3'b101);
        cyc(3'b101);
        chk("vol_a", int'(owner), 1);
        cyc(3'b100);
        chk("vol_pre", int'(preempt), 0);
`ifdef ABC_ARB_TURNAROUND_EN
        chk("vol_gap", int'(owner), 0);
        cyc(3'b100);
`endif
        chk("vol_c", int'(gnt_c), 1);
        // waiting requester withdraws
        do_reset();
        b_seen = 0;
        cyc(3'b001);
        cyc(3'b011);
        cyc(3'b001);
        cyc(3'b001);
        cyc(3'b000);
        chk("wd_idle", int'(owner), 0);
        chk("wd_busy", int'(busy), 0);
        cyc(3'b000);
        chk("wd_b_never", int'(b_seen), 0);
        // asynchronous reset mid-grant
        do_reset();
        cyc(3'b100);
        cyc(3'b100);
        chk("ar_c", int'(gnt_c), 1);
        {req_c, req_b, req_a} = 3'b101;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_gnt_c", int'(gnt_c), 0);
        chk("ar_owner", int'(owner), 0);
        chk("ar_busy", int'(busy), 0);
        m_reset();
        cyc(3'b101);
        rst_n = 1'b1;
        cyc(3'b101);
        chk("ar_first_a", int'(owner), 1);
        // randomized traffic with occasional resets
        do_reset();
        cur = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 1; b <= 3; b++)
                if ($urandom_range(3) == 0) cur[b] = ~cur[b];
            if ($urandom_range(199) == 0) do_reset();
            cyc(cur);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
